// File: rtl/rv32_regfile_sb.sv
// rv32_regfile_sb: RV32 integer register file with an integrated issue
// scoreboard. It has NUM_RD combinational read ports with writeback bypass,
// and x0 is hardwired to zero. Busy bits track destinations that have been
// issued and not yet written back.
// Optional feature macro: RV_REGFILE_PARITY_EN adds per-register even parity
// storage and a parity check on each read port.
module rv32_regfile_sb #(
   parameter int XLEN     = 32,
   parameter int NUM_REGS = 32,
   parameter int NUM_RD   = 2,
   parameter int AW       = $clog2(NUM_REGS)
) (
   input  logic                   clk_in,
   input  logic                   reset_in,
   input  logic [NUM_RD*AW-1:0]   rs_addr_in,
   output logic [NUM_RD*XLEN-1:0] rs_data_out,
   output logic [NUM_RD-1:0]      rs_ready_out,
   input  logic                   issue_valid_in,
   input  logic [AW-1:0]          issue_rd_in,
   output logic                   issue_ready_out,
   input  logic                   wb_valid_in,
   input  logic [AW-1:0]          wb_rd_in,
   input  logic [XLEN-1:0]        wb_data_in,
   output logic [NUM_REGS-1:0]    busy_out,
   output logic [NUM_RD-1:0]      parity_err_out
);

   logic [XLEN-1:0]     regs_q [NUM_REGS];
   logic [XLEN-1:0]     regs_d [NUM_REGS];
   logic [NUM_REGS-1:0] busy_q;
   logic [NUM_REGS-1:0] busy_d;
   logic                wb_write;

`ifdef RV_REGFILE_PARITY_EN
   logic [NUM_REGS-1:0] par_q;
   logic [NUM_REGS-1:0] par_d;
`endif

   // x0 is never written; the writeback strobe alone still clears busy.
   assign wb_write = wb_valid_in && (wb_rd_in != '0);

   // A writeback landing on the requested rd this cycle frees it, so a WAW
   // reservation is accepted in the same cycle as the retiring write.
   assign issue_ready_out = issue_valid_in &&
                            ((issue_rd_in == '0) || !busy_q[issue_rd_in] ||
                             (wb_valid_in && (wb_rd_in == issue_rd_in)));

   assign busy_out = busy_q;

   // Next-state for the array and scoreboard; set is applied after clear so
   // a same-cycle issue of the written rd keeps the bit busy.
   always_comb begin
      regs_d = regs_q;
      busy_d = busy_q;
`ifdef RV_REGFILE_PARITY_EN
      par_d  = par_q;
`endif
      if (wb_valid_in) begin
         busy_d[wb_rd_in] = 1'b0;
      end
      if (wb_write) begin
         regs_d[wb_rd_in] = wb_data_in;
`ifdef RV_REGFILE_PARITY_EN
         par_d[wb_rd_in]  = ^wb_data_in;
`endif
      end
      if (issue_ready_out && (issue_rd_in != '0)) begin
         busy_d[issue_rd_in] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   // Register array, parity bits and scoreboard; reset clears everything at once.
   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
         busy_q <= '0;
`ifdef RV_REGFILE_PARITY_EN
         par_q  <= '0;
`endif
      end else begin
         regs_q <= regs_d;
         busy_q <= busy_d;
`ifdef RV_REGFILE_PARITY_EN
         par_q  <= par_d;
`endif
      end
   end

   // Read ports: x0 first, then writeback bypass, then the array.
   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [AW-1:0] addr;
      logic          is_x0;
      logic          bypass;

      assign addr   = rs_addr_in[k*AW +: AW];
      assign is_x0  = (addr == '0);
      assign bypass = wb_valid_in && (wb_rd_in == addr);

      assign rs_data_out[k*XLEN +: XLEN] = is_x0  ? '0 :
                                           bypass ? wb_data_in : regs_q[addr];
      assign rs_ready_out[k] = is_x0 || bypass || !busy_q[addr];

`ifdef RV_REGFILE_PARITY_EN
      // Only array reads are checked; bypassed data never touched storage.
      assign parity_err_out[k] = (!is_x0 && !bypass) ?
                                 (par_q[addr] ^ (^regs_q[addr])) : 1'b0;
`else
      assign parity_err_out[k] = 1'b0;
`endif
   end

endmodule

// File: tb/tb_rv32_regfile_sb.sv
// tb_rv32_regfile_sb: directed, table-driven bench for rv32_regfile_sb
// (default parameters: XLEN=32, NUM_REGS=32, NUM_RD=2).
module tb_rv32_regfile_sb;

   logic        clk_in;
   logic        reset_in;
   logic [9:0]  rs_addr_in;
   logic [63:0] rs_data_out;
   logic [1:0]  rs_ready_out;
   logic        issue_valid_in;
   logic [4:0]  issue_rd_in;
   logic        issue_ready_out;
   logic        wb_valid_in;
   logic [4:0]  wb_rd_in;
   logic [31:0] wb_data_in;
   logic [31:0] busy_out;
   logic [1:0]  parity_err_out;

   int n_checks = 0;
   int n_fail   = 0;

   rv32_regfile_sb dut (
      .clk_in          (clk_in),
      .reset_in        (reset_in),
      .rs_addr_in      (rs_addr_in),
      .rs_data_out     (rs_data_out),
      .rs_ready_out    (rs_ready_out),
      .issue_valid_in  (issue_valid_in),
      .issue_rd_in     (issue_rd_in),
      .issue_ready_out (issue_ready_out),
      .wb_valid_in     (wb_valid_in),
      .wb_rd_in        (wb_rd_in),
      .wb_data_in      (wb_data_in),
      .busy_out        (busy_out),
      .parity_err_out  (parity_err_out)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   typedef struct packed {
      logic        wbv;
      logic [4:0]  wbrd;
      logic [31:0] wbd;
      logic        isv;
      logic [4:0]  isrd;
      logic [4:0]  a0;
      logic [4:0]  a1;
      logic [31:0] d0;
      logic        r0;
      logic [31:0] d1;
      logic        r1;
      logic        iss;
      logic [31:0] busy;   // busy_out expected after the clock edge
   } vec_t;

   localparam int NV = 15;
   vec_t vecs [NV];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic wbv, input logic [4:0] wbrd, input logic [31:0] wbd,
                        input logic isv, input logic [4:0] isrd,
                        input logic [4:0] a0, input logic [4:0] a1);
      wb_valid_in    = wbv;
      wb_rd_in       = wbrd;
      wb_data_in     = wbd;
      issue_valid_in = isv;
      issue_rd_in    = isrd;
      rs_addr_in     = {a1, a0};
   endtask

   initial begin
      //        wbv  wbrd   wbd           isv  isrd   a0     a1     d0            r0    d1            r1    iss   busy after
      vecs[0]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd5,  5'd0,  32'h0,        1'b1, 32'h0,        1'b1, 1'b0, 32'h0};
      vecs[1]  = '{1'b1, 5'd3,  32'hDEADBEEF, 1'b0, 5'd0,  5'd3,  5'd0,  32'hDEADBEEF, 1'b1, 32'h0,        1'b1, 1'b0, 32'h0};
      vecs[2]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd3,  5'd3,  32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0};
      vecs[3]  = '{1'b1, 5'd0,  32'h1234,     1'b0, 5'd0,  5'd0,  5'd3,  32'h0,        1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0};
      vecs[4]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd0,  5'd5,  32'h0,        1'b1, 32'h0,        1'b1, 1'b0, 32'h0};
      vecs[5]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  5'd7,  5'd3,  32'h0,        1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 32'h80};
      vecs[6]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  5'd7,  5'd3,  32'h0,        1'b0, 32'hDEADBEEF, 1'b1, 1'b0, 32'h80};
      vecs[7]  = '{1'b1, 5'd7,  32'h55,       1'b0, 5'd0,  5'd7,  5'd0,  32'h55,       1'b1, 32'h0,        1'b1, 1'b0, 32'h0};
      vecs[8]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd7,  5'd3,  32'h55,       1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0};
      vecs[9]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  5'd9,  5'd0,  32'h0,        1'b1, 32'h0,        1'b1, 1'b1, 32'h200};
      vecs[10] = '{1'b1, 5'd9,  32'hA5,       1'b1, 5'd9,  5'd9,  5'd7,  32'hA5,       1'b1, 32'h55,       1'b1, 1'b1, 32'h200};
      vecs[11] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd9,  5'd7,  32'hA5,       1'b0, 32'h55,       1'b1, 1'b0, 32'h200};
      vecs[12] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  5'd0,  5'd9,  32'h0,        1'b1, 32'hA5,       1'b0, 1'b1, 32'h200};
      vecs[13] = '{1'b1, 5'd9,  32'h1,        1'b1, 5'd4,  5'd4,  5'd9,  32'h0,        1'b1, 32'h1,        1'b1, 1'b1, 32'h10};
      vecs[14] = '{1'b1, 5'd12, 32'hCAFE,     1'b0, 5'd0,  5'd12, 5'd4,  32'hCAFE,     1'b1, 32'h0,        1'b0, 1'b0, 32'h10};

      reset_in = 1'b1;
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0);
      #12;
      reset_in = 1'b0;
      #1;
      chk("reset_busy",   64'(busy_out),        64'h0);
      chk("reset_ready",  64'(rs_ready_out),    64'h3);
      chk("reset_data",   rs_data_out,          64'h0);
      chk("reset_parity", 64'(parity_err_out),  64'h0);
      @(posedge clk_in); #1;

      // Table-driven sequence: inputs applied just after an edge, combinational
      // outputs checked mid-cycle, scoreboard checked after the next edge.
      for (int i = 0; i < NV; i++) begin
         drive(vecs[i].wbv, vecs[i].wbrd, vecs[i].wbd, vecs[i].isv, vecs[i].isrd,
               vecs[i].a0, vecs[i].a1);
         #2;
         chk($sformatf("v%0d_d0", i),  64'(rs_data_out[31:0]),  64'(vecs[i].d0));
         chk($sformatf("v%0d_r0", i),  64'(rs_ready_out[0]),    64'(vecs[i].r0));
         chk($sformatf("v%0d_d1", i),  64'(rs_data_out[63:32]), 64'(vecs[i].d1));
         chk($sformatf("v%0d_r1", i),  64'(rs_ready_out[1]),    64'(vecs[i].r1));
         chk($sformatf("v%0d_iss", i), 64'(issue_ready_out),    64'(vecs[i].iss));
         chk($sformatf("v%0d_par", i), 64'(parity_err_out),     64'h0);
         @(posedge clk_in); #1;
         chk($sformatf("v%0d_busy", i), 64'(busy_out), 64'(vecs[i].busy));
      end

      // Busy x4 (from the table) is cleared by wb x4=0x77 while x6 is reserved.
      drive(1'b1, 5'd4, 32'h77, 1'b1, 5'd6, 5'd4, 5'd6);
      @(posedge clk_in); #1;
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd6);
      #1;
      chk("pre_rst_busy", 64'(busy_out),          64'h40);
      chk("pre_rst_x4",   64'(rs_data_out[31:0]), 64'h77);
      chk("pre_rst_r6",   64'(rs_ready_out[1]),   64'h0);

      // Asynchronous reset between edges takes effect without a clock.
      #1;
      reset_in = 1'b1;
      issue_valid_in = 1'b1;
      issue_rd_in    = 5'd6;
      #1;
      chk("arst_busy",  64'(busy_out),          64'h0);
      chk("arst_x4",    64'(rs_data_out[31:0]), 64'h0);
      chk("arst_ready", 64'(rs_ready_out),      64'h3);
      chk("arst_iss",   64'(issue_ready_out),   64'h1);
      issue_valid_in = 1'b0;
      #1;
      chk("arst_iss_idle", 64'(issue_ready_out), 64'h0);
      reset_in = 1'b0;

      // After reset an in-flight writeback is a plain write; busy stays clear.
      @(posedge clk_in); #1;
      drive(1'b1, 5'd6, 32'h11, 1'b0, 5'd0, 5'd4, 5'd6);
      @(posedge clk_in); #1;
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd6);
      #1;
      chk("post_rst_x6",   64'(rs_data_out[63:32]), 64'h11);
      chk("post_rst_r6",   64'(rs_ready_out[1]),    64'h1);
      chk("post_rst_busy", 64'(busy_out),           64'h0);

`ifdef RV_REGFILE_PARITY_EN
      // Corrupt the stored parity of x2 and read it back through port 1.
      drive(1'b1, 5'd2, 32'h3, 1'b0, 5'd0, 5'd0, 5'd2);
      @(posedge clk_in); #1;
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd2);
      #1;
      chk("par_clean", 64'(parity_err_out), 64'h0);
      force dut.par_q[2] = 1'b1;
      #1;
      chk("par_err",      64'(parity_err_out),      64'h2);
      chk("par_err_data", 64'(rs_data_out[63:32]),  64'h3);
      release dut.par_q[2];
`endif

      @(posedge clk_in); #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
